bram_fifo_ctl: RTL and testbench

Synchronous FIFO controller that drives a dual-port generic_bram instance as its storage array.
- Push side writes through BRAM port A; pop side reads through BRAM port B.
- A 2-entry registered output buffer absorbs the 1-cycle BRAM read latency, so pop_vld/pop_rdy streaming runs at full rate.
- Sits directly upstream of the BRAM and is the standard FIFO front-end for BRAM-backed queues.

---
 rtl/bram_fifo_pkg.sv | 17 +
 rtl/bram_fifo_obuf.sv | 66 ++++++
 rtl/bram_fifo_ctl.sv | 121 ++++++++++++
 tb/tb_bram_fifo_ctl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared helpers for the BRAM-backed FIFO controller.
//   ptr_diff: modular difference of two wrap-bit pointers, masked to w bits.
package bram_fifo_pkg;

    // Entries between rd and wr pointers; pointers carry a wrap bit so the
    // result distinguishes empty (0) from full (2^(w-1)).
    function automatic logic [31:0] ptr_diff(
        input logic [31:0] wr,
        input logic [31:0] rd,
        input int unsigned w
    );
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/bram_fifo_obuf.sv
// Two-entry in-order output queue that absorbs the BRAM read latency.
//   clk, arst_n : clock, async active-low reset
//   flush       : synchronous clear (drops any capture in the same cycle)
//   cap_vld/dat : word returning from the BRAM this cycle
//   pop_rdy     : consumer ready; pop when pop_vld & pop_rdy
//   pop_vld/dat : registered head of queue
//   cnt         : entries held (0..2), used for the read-issue credit
module bram_fifo_obuf #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              flush,
    input  logic              cap_vld,
    input  logic [WORD_W-1:0] cap_dat,
    input  logic              pop_rdy,
    output logic              pop_vld,
    output logic [WORD_W-1:0] pop_dat,
    output logic [1:0]        cnt
);

    logic              vld0, vld1;
    logic [WORD_W-1:0] dat0, dat1;
    logic              pop;

    assign pop     = vld0 & pop_rdy;
    assign pop_vld = vld0;
    assign pop_dat = dat0;
    // vld1 is only ever set while vld0 is set
    assign cnt     = {vld0 & vld1, vld0 ^ vld1};

    // Queue update; a capture and a pop in the same cycle are both honoured
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld0 <= 1'b0;
            vld1 <= 1'b0;
            dat0 <= '0;
            dat1 <= '0;
        end else if (flush) begin
            vld0 <= 1'b0;
            vld1 <= 1'b0;
        end else if (pop) begin
            if (vld1) begin
                dat0 <= dat1;
                if (cap_vld) begin
                    dat1 <= cap_dat;
                end else begin
                    vld1 <= 1'b0;
                end
            end else if (cap_vld) begin
                dat0 <= cap_dat;
            end else begin
                vld0 <= 1'b0;
            end
        end else if (cap_vld) begin
            if (!vld0) begin
                dat0 <= cap_dat;
                vld0 <= 1'b1;
            end else begin
                dat1 <= cap_dat;
                vld1 <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_fifo_ctl.sv
// Synchronous FIFO controller driving an external dual-port BRAM.
// Port A writes pushed words, port B prefetches into a 2-entry output queue.
//   clk, arst_n          : clock, async active-low reset
//   flush                : synchronous clear of all contents
//   push_vld/dat/rdy     : write handshake
//   pop_vld/dat/rdy      : read handshake (registered head)
//   bram_cea/addra/dina  : BRAM port A (write only, bram_rnwa = 0)
//   bram_ceb/addrb/doutb : BRAM port B (read only, bram_rnwb = 1, 1-cycle latency)
//   occupancy/empty/full : status; full reflects the BRAM array only
module bram_fifo_ctl
    import bram_fifo_pkg::*;
#(
    parameter  int unsigned WORD_W  = 32,
    parameter  int unsigned WORDS_N = 256,
    localparam int unsigned ADDR_W  = $clog2(WORDS_N),
    localparam int unsigned CNT_W   = $clog2(WORDS_N + 2) + 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              flush,
    input  logic              push_vld,
    input  logic [WORD_W-1:0] push_dat,
    output logic              push_rdy,
    output logic              pop_vld,
    output logic [WORD_W-1:0] pop_dat,
    input  logic              pop_rdy,
    output logic              bram_cea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [WORD_W-1:0] bram_dina,
    output logic              bram_rnwa,
    output logic              bram_ceb,
    output logic [ADDR_W-1:0] bram_addrb,
    output logic              bram_rnwb,
    input  logic [WORD_W-1:0] bram_doutb,
    output logic [CNT_W-1:0]  occupancy,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] bram_cnt;
    logic             inflight;
    logic [CNT_W-1:0] occ_q;
    logic [1:0]       obuf_cnt;
    logic             full_c;
    logic             push_acc, pop_hs, pop_acc, rd_issue;

    assign bram_cnt = PTR_W'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PTR_W));
    assign full_c   = (bram_cnt == PTR_W'(WORDS_N));

    assign push_rdy = ~full_c;
    assign full     = full_c;
    assign push_acc = push_vld & ~full_c & ~flush;
    assign pop_hs   = pop_vld & pop_rdy;
    assign pop_acc  = pop_hs & ~flush;

    // Prefetch when BRAM has data and the queue (plus the read in flight)
    // has room, counting the slot freed by a pop this cycle. bram_cnt != 0
    // means the head entry was written in an earlier cycle, so the read
    // address never equals this cycle's write address.
    assign rd_issue = ~flush & (bram_cnt != '0) &
                      ((3'(obuf_cnt) + 3'(inflight)) < (3'd2 + 3'(pop_hs)));

    // Write port: combinational from the push handshake, forced idle in reset
    assign bram_cea   = push_acc & arst_n;
    assign bram_addra = wr_ptr[ADDR_W-1:0];
    assign bram_dina  = bram_cea ? push_dat : '0;
    assign bram_rnwa  = 1'b0;

    assign bram_ceb   = rd_issue;
    assign bram_addrb = rd_ptr[ADDR_W-1:0];
    assign bram_rnwb  = 1'b1;

    assign occupancy = occ_q;
    assign empty     = (occ_q == '0);

    // Pointers, in-flight flag and occupancy
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            occ_q    <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            inflight <= rd_issue;
            unique case ({push_acc, pop_acc})
                2'b10:   occ_q <= occ_q + CNT_W'(1);
                2'b01:   occ_q <= occ_q - CNT_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    bram_fifo_obuf #(
        .WORD_W (WORD_W)
    ) u_obuf (
        .clk     (clk),
        .arst_n  (arst_n),
        .flush   (flush),
        .cap_vld (inflight),
        .cap_dat (bram_doutb),
        .pop_rdy (pop_rdy),
        .pop_vld (pop_vld),
        .pop_dat (pop_dat),
        .cnt     (obuf_cnt)
    );

endmodule

// File: tb/tb_bram_fifo_ctl.sv
// Directed/random bench for bram_fifo_ctl with a behavioural BRAM and a
// queue scoreboard filled on push accept and drained on pop accept.
module tb_bram_fifo_ctl;

    localparam int WORD_W  = 32;
    localparam int WORDS_N = 8;
    localparam int ADDR_W  = $clog2(WORDS_N);
    localparam int CNT_W   = $clog2(WORDS_N + 2) + 1;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              flush;
    logic              push_vld;
    logic [WORD_W-1:0] push_dat;
    logic              push_rdy;
    logic              pop_vld;
    logic [WORD_W-1:0] pop_dat;
    logic              pop_rdy;
    logic              bram_cea;
    logic [ADDR_W-1:0] bram_addra;
    logic [WORD_W-1:0] bram_dina;
    logic              bram_rnwa;
    logic              bram_ceb;
    logic [ADDR_W-1:0] bram_addrb;
    logic              bram_rnwb;
    logic [WORD_W-1:0] bram_doutb;
    logic [CNT_W-1:0]  occupancy;
    logic              empty;
    logic              full;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [WORD_W-1:0] sb[$];
    logic [WORD_W-1:0] mem[WORDS_N];

    always #5 clk = ~clk;

    bram_fifo_ctl #(
        .WORD_W  (WORD_W),
        .WORDS_N (WORDS_N)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .flush      (flush),
        .push_vld   (push_vld),
        .push_dat   (push_dat),
        .push_rdy   (push_rdy),
        .pop_vld    (pop_vld),
        .pop_dat    (pop_dat),
        .pop_rdy    (pop_rdy),
        .bram_cea   (bram_cea),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_rnwa  (bram_rnwa),
        .bram_ceb   (bram_ceb),
        .bram_addrb (bram_addrb),
        .bram_rnwb  (bram_rnwb),
        .bram_doutb (bram_doutb),
        .occupancy  (occupancy),
        .empty      (empty),
        .full       (full)
    );

    // Behavioural dual-port BRAM, 1-cycle read latency
    always @(posedge clk) begin
        if (bram_cea && !bram_rnwa) mem[bram_addra] <= bram_dina;
        if (bram_ceb && bram_rnwb)  bram_doutb <= mem[bram_addrb];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and per-cycle invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (!arst_n) begin
            sb.delete();
        end else begin
            chk("occ", 64'(occupancy), 64'(sb.size()));
            chk("empty", 64'(empty), 64'(sb.size() == 0));
            chk("occ_max", 64'(64'(occupancy) > 64'(WORDS_N + 2)), 64'(0));
            chk("cea", 64'(bram_cea), 64'(push_vld && push_rdy && !flush));
            if (bram_cea) chk("push_full", 64'(full), 64'(0));
            if (bram_cea && bram_ceb) chk("collide", 64'(bram_addra == bram_addrb), 64'(0));
            if (sb.size() < WORDS_N) chk("full_lo", 64'(full), 64'(0));
            if (sb.size() == WORDS_N + 2) chk("full_hi", 64'(full), 64'(1));
            if (flush) begin
                sb.delete();
            end else begin
                if (pop_vld && pop_rdy) begin
                    if (sb.size() == 0) chk("pop_unexp", 64'(pop_vld), 64'(0));
                    else chk("pop_dat", 64'(pop_dat), 64'(sb.pop_front()));
                end
                if (push_vld && push_rdy) sb.push_back(push_dat);
            end
        end
    end

    task automatic drain(input string tag);
        push_vld = 1'b0;
        pop_rdy  = 1'b1;
        flush    = 1'b0;
        for (int i = 0; i < 60 && (empty !== 1'b1); i++) cyc();
        @(negedge clk);
        chk($sformatf("%s_empty", tag), 64'(empty), 64'(1));
        chk($sformatf("%s_sb", tag), 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int cycles;
        int dev;
        int wraps;
        int got;
        logic [CNT_W-1:0] occ0;

        arst_n = 1'b1; flush = 1'b0; push_vld = 1'b0; push_dat = '0; pop_rdy = 1'b0;
        #1 arst_n = 1'b0;
        push_vld = 1'b1;
        push_dat = 32'hFFFF_FFFF;
        #2;
        chk("rst_push_rdy", 64'(push_rdy), 64'(1));
        chk("rst_pop_vld", 64'(pop_vld), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_cea", 64'(bram_cea), 64'(0));
        chk("rst_ceb", 64'(bram_ceb), 64'(0));
        chk("rst_occ", 64'(occupancy), 64'(0));
        chk("rst_addra", 64'(bram_addra), 64'(0));
        chk("rst_addrb", 64'(bram_addrb), 64'(0));
        chk("rst_dina", 64'(bram_dina), 64'(0));
        push_vld = 1'b0;
        push_dat = '0;
        @(posedge clk);
        @(posedge clk);
        #2 arst_n = 1'b1;

        // 1: single word latency
        cyc(); push_vld = 1'b1; push_dat = 32'hA5A5_0001; pop_rdy = 1'b1;
        @(negedge clk);
        chk("t1_cea", 64'(bram_cea), 64'(1));
        chk("t1_addra", 64'(bram_addra), 64'(0));
        chk("t1_dina", 64'(bram_dina), 64'hA5A5_0001);
        chk("t1_ceb0", 64'(bram_ceb), 64'(0));
        cyc(); push_vld = 1'b0;
        @(negedge clk);
        chk("t1_ceb1", 64'(bram_ceb), 64'(1));
        chk("t1_addrb", 64'(bram_addrb), 64'(0));
        chk("t1_occ1", 64'(occupancy), 64'(1));
        cyc();
        @(negedge clk);
        chk("t1_vld2", 64'(pop_vld), 64'(0));
        cyc();
        @(negedge clk);
        chk("t1_vld3", 64'(pop_vld), 64'(1));
        chk("t1_dat3", 64'(pop_dat), 64'hA5A5_0001);
        cyc();
        @(negedge clk);
        chk("t1_occ4", 64'(occupancy), 64'(0));
        chk("t1_empty4", 64'(empty), 64'(1));

        // 2: fill to capacity, then drain in order
        pop_rdy = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(); push_vld = 1'b1; push_dat = 32'(i);
            @(negedge clk);
            if (push_vld && push_rdy) acc++;
        end
        cyc(); push_vld = 1'b0;
        @(negedge clk);
        chk("t2_acc", 64'(acc), 64'(10));
        chk("t2_full", 64'(full), 64'(1));
        chk("t2_push_rdy", 64'(push_rdy), 64'(0));
        chk("t2_occ", 64'(occupancy), 64'(10));
        cyc(); pop_rdy = 1'b1; push_vld = 1'b1; push_dat = 32'hDEAD_0000;
        @(negedge clk);
        chk("t2_refused", 64'(push_rdy), 64'(0));
        chk("t2_issue", 64'(bram_ceb), 64'(1));
        cyc(); push_vld = 1'b0;
        @(negedge clk);
        chk("t2_rdy_back", 64'(push_rdy), 64'(1));
        drain("t2");

        // 3: streaming push+pop every cycle
        cyc(); push_vld = 1'b1; pop_rdy = 1'b1;
        dev = 0; wraps = 0; occ0 = '0;
        for (int i = 0; i < 1000; i++) begin
            push_dat = $urandom();
            @(negedge clk);
            if (i == 10) occ0 = occupancy;
            if (i > 10 && occupancy !== occ0) dev++;
            if (bram_cea && bram_addra == ADDR_W'(WORDS_N - 1)) wraps++;
            cyc();
        end
        chk("t3_occ_val", 64'(occ0), 64'(3));
        chk("t3_occ_dev", 64'(dev), 64'(0));
        chk("t3_wraps", 64'(wraps >= 100), 64'(1));
        drain("t3");

        // 4: random push/pop traffic
        acc = 0; cycles = 0;
        while (acc < 10000 && cycles < 40000) begin
            cyc();
            push_vld = ($urandom_range(0, 99) < 70);
            push_dat = $urandom();
            pop_rdy  = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            if (push_vld && push_rdy) acc++;
            cycles++;
        end
        chk("t4_count", 64'(acc), 64'(10000));
        drain("t4");

        // 5: flush with a read in flight
        pop_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); push_vld = 1'b1; push_dat = 32'h5000 + 32'(i);
        end
        cyc(); push_vld = 1'b0;
        repeat (4) cyc();
        pop_rdy = 1'b1; push_vld = 1'b1; push_dat = 32'h5005;
        @(negedge clk);
        chk("t5_issue", 64'(bram_ceb), 64'(1));
        cyc(); flush = 1'b1; push_vld = 1'b1; push_dat = 32'h0BAD_0BAD; pop_rdy = 1'b1;
        @(negedge clk);
        chk("t5_occ_pre", 64'(occupancy), 64'(5));
        chk("t5_rdy_shown", 64'(push_rdy), 64'(1));
        chk("t5_vld_shown", 64'(pop_vld), 64'(1));
        cyc(); flush = 1'b0; push_vld = 1'b0;
        @(negedge clk);
        chk("t5_occ_post", 64'(occupancy), 64'(0));
        chk("t5_vld_post", 64'(pop_vld), 64'(0));
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("t5_no_stale", 64'(pop_vld), 64'(0));
        end
        cyc(); push_vld = 1'b1; push_dat = 32'h1234;
        cyc(); push_vld = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(negedge clk);
            if (pop_vld === 1'b1) begin
                got = 1;
                chk("t5_dat", 64'(pop_dat), 64'h1234);
            end else begin
                cyc();
            end
        end
        chk("t5_seen", 64'(got), 64'(1));
        drain("t5");

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 20; i++) begin
            cyc();
            push_vld = ($urandom_range(0, 99) < 80);
            push_dat = $urandom();
            pop_rdy  = ($urandom_range(0, 99) < 50);
        end
        cyc(); push_vld = 1'b1; push_dat = 32'h6666_0000; pop_rdy = 1'b1;
        #2 arst_n = 1'b0;
        #1;
        chk("t6_push_rdy", 64'(push_rdy), 64'(1));
        chk("t6_pop_vld", 64'(pop_vld), 64'(0));
        chk("t6_cea", 64'(bram_cea), 64'(0));
        chk("t6_ceb", 64'(bram_ceb), 64'(0));
        chk("t6_occ", 64'(occupancy), 64'(0));
        chk("t6_empty", 64'(empty), 64'(1));
        cyc();
        cyc();
        #1 arst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(); push_vld = 1'b1; push_dat = 32'h6000 + 32'(i); pop_rdy = 1'b1;
        end
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
